uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx.sv | 109 ++++++++++
 tb/tb_uart_tx.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART transmitter.
//   tx_state_t            : transmitter FSM state (IDLE, XMIT)
//   UART_BAUD_DIV_DEFAULT : clocks per bit for 19200 baud from 50 MHz
//   UART_FRAME_BITS       : bits per frame (11 with UART_TX_PARITY_EN, else 10)
//   uart_frame()          : builds the LSB-first shift-register image of a frame
// Optional feature macro: UART_TX_PARITY_EN (even parity bit before stop).
package uart_pkg;

   typedef enum logic {IDLE = 1'b0, XMIT = 1'b1} tx_state_t;

   localparam int UART_BAUD_DIV_DEFAULT = 2604;
   localparam int UART_DATA_BITS        = 8;
   localparam int UART_BAUD_CNT_W       = 13;
   localparam int UART_BIT_CNT_W        = 4;
`ifdef UART_TX_PARITY_EN
   localparam int UART_FRAME_BITS       = 11;
`else
   localparam int UART_FRAME_BITS       = 10;
`endif

   // Bit 0 goes on the line first: start(0), data LSB first, [parity], stop(1).
   function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [UART_DATA_BITS-1:0] d);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {1'b1, d, 1'b0};
`endif
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if -- byte-in / serial-out bundle of the UART transmitter.
//   trmt    : one-cycle strobe, enqueues tx_data
//   tx_data : byte to send, sampled with trmt
//   TX      : serial line, idle high
//   tx_done : sticky, set when the queue drains and the last stop bit ends
//   busy    : frame on the line or bytes queued
//   full    : transmit queue full
// master drives bytes (host side), slave is the transmitter.
interface uart_tx_if;
   import uart_pkg::*;

   logic                      trmt;
   logic [UART_DATA_BITS-1:0] tx_data;
   logic                      TX;
   logic                      tx_done;
   logic                      busy;
   logic                      full;

   modport master (output trmt, tx_data, input TX, tx_done, busy, full);
   modport slave  (input trmt, tx_data, output TX, tx_done, busy, full);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- byte queue feeding the transmitter.
//   clk, rst_n : clock, synchronous active-low reset (empties the queue)
//   wr_en/wr_data : push (caller only pushes when not full, or while popping)
//   rd_en/rd_data : pop; rd_data shows the head combinationally
//   full, empty, count : occupancy
// DEPTH must be a power of 2 so the pointers wrap on their own.
module uart_tx_fifo #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // When full, a push and a pop share a slot: the head is consumed this
   // cycle and the new byte lands there at the same edge.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- queued UART transmitter, 8 data bits, 1 stop bit.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset; aborts any frame, drops the queue
//   tx_if : uart_tx_if.slave (trmt, tx_data in; TX, tx_done, busy, full out)
// Parameters: BAUD_DIV clocks per bit (16..8191), FIFO_DEPTH queue entries
// (power of 2, 2..16).
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = UART_BAUD_DIV_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_tx_if.slave tx_if
);

   localparam int FB = UART_FRAME_BITS;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t                  state, state_nxt;
   logic [FB-1:0]              shreg;
   logic [UART_BAUD_CNT_W-1:0] baud_cnt;
   logic [UART_BIT_CNT_W-1:0]  bit_cnt;
   logic                       tx_done_r;

   logic          pop, set_done, wr_en, baud_tick, frame_end;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_rd_data;
   logic [CW-1:0] fifo_count;

   // A strobe while full is still taken if the head leaves in the same cycle.
   assign wr_en = tx_if.trmt && (!fifo_full || pop);

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data (tx_if.tx_data),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign baud_tick = (state == XMIT) && (baud_cnt == UART_BAUD_CNT_W'(BAUD_DIV - 1));
   // Frame ends on the tick that would shift out the stop bit, so the next
   // frame can be loaded in its place without an idle cycle.
   assign frame_end = baud_tick && (bit_cnt == UART_BIT_CNT_W'(FB - 1));

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      set_done  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = XMIT;
            end
         end
         XMIT: begin
            if (frame_end) begin
               if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  set_done  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '1;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         tx_done_r <= 1'b0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            shreg    <= uart_frame(fifo_rd_data);
            baud_cnt <= '0;
            bit_cnt  <= '0;
         end else if (baud_tick) begin
            shreg    <= {1'b1, shreg[FB-1:1]};
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
         end else if (state == XMIT) begin
            baud_cnt <= baud_cnt + 1'b1;
         end
         // An accepted strobe beats a same-cycle set.
         if (wr_en)         tx_done_r <= 1'b0;
         else if (set_done) tx_done_r <= 1'b1;
      end
   end

   assign tx_if.TX      = shreg[0];
   assign tx_if.tx_done = tx_done_r;
   assign tx_if.busy    = (state == XMIT) || (fifo_count != '0);
   assign tx_if.full    = fifo_full;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx (BAUD_DIV=16, FIFO_DEPTH=4).
// A line monitor decodes TX into frames; a timing model predicts, from the
// strobe cycles alone, which bytes are accepted and when each frame starts.
module tb_uart_tx;
   localparam int BD    = 16;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FL = FB * BD;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   uart_tx_if tif ();
   uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tx_if (tif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- line monitor ----------------
   typedef struct { int start; logic [7:0] data; logic par; logic ok; } rx_t;
   rx_t rx_q[$];

   initial begin : mon
      rx_t f;
      logic st, sp;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tif.TX === 1'b0) begin
            f.start = cyc;
            f.par   = 1'b0;
            sp      = 1'b0;
            repeat (BD/2) @(negedge clk);
            st = (tif.TX === 1'b0);
            for (int k = 1; k < FB; k++) begin
               repeat (BD) @(negedge clk);
               if (k <= 8)          f.data[k-1] = tif.TX;
               else if (k == FB-1)  sp = tif.TX;
               else                 f.par = tif.TX;
            end
`ifdef UART_TX_PARITY_EN
            f.ok = st && (sp === 1'b1) && (f.par === ^f.data);
`else
            f.ok = st && (sp === 1'b1);
`endif
            repeat (BD/2 - 1) @(negedge clk);
            rx_q.push_back(f);
         end
      end
   end

   // ---------------- reference model ----------------
   // A byte strobed in cycle w starts on the line at max(w+2, end of the
   // previous frame) and leaves the queue the cycle before it starts.
   typedef struct { int w; int s; logic [7:0] data; } exp_t;
   exp_t exp_q[$];
   int   m_pop[$];
   int   m_end;

   task automatic model_reset();
      exp_q.delete(); m_pop.delete(); rx_q.delete(); m_end = 0;
   endtask

   task automatic model_strobe(input int w, input logic [7:0] d);
      int   n;
      exp_t e;
      n = 0;
      foreach (m_pop[i]) if (m_pop[i] > w) n++;
      if (n < DEPTH) begin
         e.w = w; e.data = d;
         e.s = (w + 2 > m_end) ? w + 2 : m_end;
         m_end = e.s + FL;
         m_pop.push_back(e.s - 1);
         exp_q.push_back(e);
      end
   endtask

   function automatic logic m_full(input int t);
      int n;
      n = 0;
      foreach (m_pop[i]) if (m_pop[i] >= t) n++;
      return n >= DEPTH;
   endfunction

   function automatic logic m_busy(input int t);
      foreach (exp_q[i]) if (t > exp_q[i].w && t < exp_q[i].s + FL) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [FB-1:0] ref_frame(input logic [7:0] d);
      logic [FB-1:0] f;
      f = '1;
      f[0] = 1'b0;
      f[8:1] = d;
`ifdef UART_TX_PARITY_EN
      f[9] = ^d;
`endif
      return f;
   endfunction

   // Called just after a negedge; returns one negedge later.
   task automatic strobe(input logic [7:0] d);
      model_strobe(cyc, d);
      tif.trmt = 1'b1; tif.tx_data = d;
      @(negedge clk);
      tif.trmt = 1'b0; tif.tx_data = 8'($urandom);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; tif.trmt = 1'b0; tif.tx_data = 8'h00;
      repeat (3) @(negedge clk);
      checks++; if (tif.TX !== 1'b1)      begin errors++; $display("FAIL reset_TX: got %b expected 1", tif.TX); end
      checks++; if (tif.tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b expected 0", tif.tx_done); end
      checks++; if (tif.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", tif.busy); end
      checks++; if (tif.full !== 1'b0)    begin errors++; $display("FAIL reset_full: got %b expected 0", tif.full); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      logic [FB-1:0] fr;
      int bad;
      model_reset();
      fr = ref_frame(8'hA5);
      strobe(8'hA5);
      checks++; if (tif.TX !== 1'b1)   begin errors++; $display("FAIL single_latency: TX got %b expected 1 in cycle N+1", tif.TX); end
      checks++; if (tif.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", tif.busy); end
      for (int j = 0; j < FB; j++) begin
         bad = 0;
         repeat (BD) begin
            @(negedge clk);
            if (tif.TX !== fr[j]) bad++;
         end
         checks++; if (bad != 0) begin errors++; $display("FAIL single_bit%0d: %0d of %0d cycles differ from expected %b", j, bad, BD, fr[j]); end
      end
      checks++; if (tif.tx_done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b expected 0", tif.tx_done); end
      @(negedge clk);
      checks++; if (tif.tx_done !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1 at cycle 2+%0d", tif.tx_done, FL); end
      checks++; if (tif.busy !== 1'b0)    begin errors++; $display("FAIL single_idle_busy: got %b expected 0", tif.busy); end
      checks++; if (tif.TX !== 1'b1)      begin errors++; $display("FAIL single_idle_TX: got %b expected 1", tif.TX); end
   endtask

   task automatic test_back_to_back();
      int bad;
      model_reset();
      strobe(8'h00);
      strobe(8'hFF);
      bad = 0;
      repeat (2*FL) begin
         if (tif.busy !== m_busy(cyc)) bad++;
         @(negedge clk);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_busy: %0d cycles wrong", bad); end
      repeat (20) @(negedge clk);
      checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d frames expected %0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
         checks++;
         if (rx_q[i].data !== exp_q[i].data || rx_q[i].start != exp_q[i].s || rx_q[i].ok !== 1'b1) begin
            errors++; $display("FAIL b2b_frame%0d: got %h@%0d ok=%b expected %h@%0d", i, rx_q[i].data, rx_q[i].start, rx_q[i].ok, exp_q[i].data, exp_q[i].s);
         end
      end
   endtask

   task automatic test_overflow();
      model_reset();
      strobe(8'($urandom));
      repeat (4) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         checks++; if (tif.full !== m_full(cyc)) begin errors++; $display("FAIL ovf_full%0d: got %b expected %b", i, tif.full, m_full(cyc)); end
         strobe(8'($urandom));
      end
      checks++; if (tif.full !== 1'b1) begin errors++; $display("FAIL ovf_full_end: got %b expected 1", tif.full); end
      repeat (6*FL) @(negedge clk);
      checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL ovf_count: got %0d frames expected 5", rx_q.size()); end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
         checks++;
         if (rx_q[i].data !== exp_q[i].data || rx_q[i].start != exp_q[i].s || rx_q[i].ok !== 1'b1) begin
            errors++; $display("FAIL ovf_frame%0d: got %h@%0d ok=%b expected %h@%0d", i, rx_q[i].data, rx_q[i].start, rx_q[i].ok, exp_q[i].data, exp_q[i].s);
         end
      end
      checks++; if (tif.tx_done !== 1'b1 || tif.busy !== 1'b0 || tif.full !== 1'b0) begin
         errors++; $display("FAIL ovf_drain: done/busy/full got %b%b%b expected 100", tif.tx_done, tif.busy, tif.full);
      end
   endtask

   task automatic test_done_clear();
      logic [7:0] d1, d2;
      model_reset();
      d1 = 8'($urandom); d2 = 8'($urandom);
      strobe(d1);
      repeat (FL) @(negedge clk);
      checks++; if (tif.tx_done !== 1'b0) begin errors++; $display("FAIL clr_pre: tx_done got %b expected 0", tif.tx_done); end
      strobe(d2);
      checks++; if (tif.tx_done !== 1'b0) begin errors++; $display("FAIL clr_done: got %b expected 0", tif.tx_done); end
      checks++; if (tif.busy !== 1'b1)    begin errors++; $display("FAIL clr_busy: got %b expected 1", tif.busy); end
      @(negedge clk);
      checks++; if (tif.TX !== 1'b0) begin errors++; $display("FAIL clr_start: TX got %b expected 0", tif.TX); end
      repeat (FL + 10) @(negedge clk);
      checks++; if (tif.tx_done !== 1'b1) begin errors++; $display("FAIL clr_final_done: got %b expected 1", tif.tx_done); end
      checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL clr_count: got %0d frames expected 2", rx_q.size()); end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
         checks++;
         if (rx_q[i].data !== exp_q[i].data || rx_q[i].start != exp_q[i].s || rx_q[i].ok !== 1'b1) begin
            errors++; $display("FAIL clr_frame%0d: got %h@%0d ok=%b expected %h@%0d", i, rx_q[i].data, rx_q[i].start, rx_q[i].ok, exp_q[i].data, exp_q[i].s);
         end
      end
   endtask

   task automatic test_parity();
      model_reset();
      strobe(8'h07);
      strobe(8'h03);
      repeat (2*FL + 10) @(negedge clk);
      checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL par_count: got %0d frames expected 2", rx_q.size()); end
      if (rx_q.size() == 2) begin
         checks++; if (rx_q[1].start - rx_q[0].start != FL) begin
            errors++; $display("FAIL par_frame_len: got %0d clocks expected %0d", rx_q[1].start - rx_q[0].start, FL);
         end
         checks++; if (rx_q[0].data !== 8'h07 || rx_q[1].data !== 8'h03) begin
            errors++; $display("FAIL par_data: got %h %h expected 07 03", rx_q[0].data, rx_q[1].data);
         end
`ifdef UART_TX_PARITY_EN
         checks++; if (rx_q[0].par !== 1'b1) begin errors++; $display("FAIL par_bit_07: got %b expected 1", rx_q[0].par); end
         checks++; if (rx_q[1].par !== 1'b0) begin errors++; $display("FAIL par_bit_03: got %b expected 0", rx_q[1].par); end
`endif
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      model_reset();
      strobe(8'h3C);
      strobe(8'($urandom));
      strobe(8'($urandom));
      // now cycle N+3; data bit 4 occupies cycles N+82..N+97
      repeat (85) @(negedge clk);
      checks++; if (tif.busy !== 1'b1) begin errors++; $display("FAIL rmid_pre_busy: got %b expected 1", tif.busy); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (tif.TX !== 1'b1)   begin errors++; $display("FAIL rmid_TX: got %b expected 1", tif.TX); end
      checks++; if (tif.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", tif.busy); end
      checks++; if (tif.full !== 1'b0 || tif.tx_done !== 1'b0) begin
         errors++; $display("FAIL rmid_flags: full/done got %b%b expected 00", tif.full, tif.tx_done);
      end
      repeat (2*FL) @(negedge clk);
      rx_q.delete();
      bad = 0;
      repeat (3*FL) begin
         @(negedge clk);
         if (tif.TX !== 1'b1 || tif.busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0)        begin errors++; $display("FAIL rmid_quiet: %0d cycles not idle", bad); end
      checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rmid_frames: got %0d frames expected 0", rx_q.size()); end
   endtask

   task automatic test_random();
      int gap, r;
      model_reset();
      for (int n = 0; n < 16; n++) begin
         r = $urandom_range(0, 3);
         gap = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, 8) : $urandom_range(FL/2, 2*FL);
         repeat (gap) @(negedge clk);
         checks++; if (tif.full !== m_full(cyc)) begin errors++; $display("FAIL rnd_full%0d: got %b expected %b", n, tif.full, m_full(cyc)); end
         checks++; if (tif.busy !== m_busy(cyc)) begin errors++; $display("FAIL rnd_busy%0d: got %b expected %b", n, tif.busy, m_busy(cyc)); end
         strobe(8'($urandom));
      end
      repeat (m_end - cyc + 10) @(negedge clk);
      checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d frames expected %0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
         checks++;
         if (rx_q[i].data !== exp_q[i].data || rx_q[i].start != exp_q[i].s || rx_q[i].ok !== 1'b1) begin
            errors++; $display("FAIL rnd_frame%0d: got %h@%0d ok=%b expected %h@%0d", i, rx_q[i].data, rx_q[i].start, rx_q[i].ok, exp_q[i].data, exp_q[i].s);
         end
      end
      checks++; if (tif.tx_done !== 1'b1 || tif.busy !== 1'b0) begin
         errors++; $display("FAIL rnd_drain: done/busy got %b%b expected 10", tif.tx_done, tif.busy);
      end
   endtask

   initial begin
      tif.trmt    = 1'b0;
      tif.tx_data = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_done_clear();
      test_parity();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
